// File: rtl/parcheck_pkg.sv
// Shared types and default sizes for the parity-check scheduler.
package parcheck_pkg;
  localparam int unsigned DEF_WIDTH = 9;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RESP
  } state_t;
endpackage

// File: rtl/parcheck_sched_parity.sv
// Combinational parity of one word: odd = XOR-reduction, even = its inverse.
module parity_unit #(
  parameter int unsigned WIDTH = parcheck_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_word,
  output logic             o_even,
  output logic             o_odd
);
  assign o_odd  = ^i_word;
  assign o_even = ~o_odd;
endmodule

// File: rtl/parcheck_sched.sv
// Two-requester round-robin parity checker: IDLE -> CHECK -> RESP, one check per 3 cycles,
// with saturating per-requester mismatch counters.
module parcheck_sched
  import parcheck_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_odd,
  input  logic             clr_cnt,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_even,
  output logic             res_odd,
  output logic             res_ok,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1
);
  state_t           r_state, w_next;
  logic             w_start, w_win;
  logic             r_prio, r_id, r_cfg;
  logic [WIDTH-1:0] r_word;
  logic             w_even, w_odd;
  logic             r_res_id, r_res_even, r_res_odd, r_res_ok;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  parity_unit #(.WIDTH(WIDTH)) u_parity (
    .i_word (r_word),
    .o_even (w_even),
    .o_odd  (w_odd)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_win   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_start = 1'b1;
          w_next  = ST_CHECK;
          // r_prio names the requester that wins a tie
          w_win   = (req0 && req1) ? r_prio : req1;
        end
      end
      ST_CHECK: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_id       <= 1'b0;
      r_cfg      <= 1'b0;
      r_word     <= '0;
      r_res_id   <= 1'b0;
      r_res_even <= 1'b0;
      r_res_odd  <= 1'b0;
      r_res_ok   <= 1'b0;
    end else begin
      if (w_start) begin
        r_word <= w_win ? data1 : data0;
        r_cfg  <= cfg_odd;
        r_id   <= w_win;
        r_prio <= ~w_win;
      end
      if (r_state == ST_CHECK) begin
        r_res_id   <= r_id;
        r_res_even <= w_even;
        r_res_odd  <= w_odd;
        r_res_ok   <= (w_odd == r_cfg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (r_state == ST_RESP && !r_res_ok) begin
      if (!r_res_id && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if ( r_res_id && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign gnt0      = (r_state == ST_CHECK) && !r_id;
  assign gnt1      = (r_state == ST_CHECK) &&  r_id;
  assign res_valid = (r_state == ST_RESP);
  assign res_id    = r_res_id;
  assign res_even  = r_res_even;
  assign res_odd   = r_res_odd;
  assign res_ok    = r_res_ok;
  assign err_cnt0  = r_cnt0;
  assign err_cnt1  = r_cnt1;
endmodule

// File: tb/tb_parcheck_sched.sv
// Scoreboard bench for parcheck_sched: directed checks push expected results, a monitor pops them.
module tb_parcheck_sched;
  localparam int unsigned WIDTH = 9;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_odd, clr_cnt, req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, res_valid, res_id, res_even, res_odd, res_ok;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  sb_q[$];
  time         t_prev, t_now;

  parcheck_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .clr_cnt(clr_cnt),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_id(res_id),
    .res_even(res_even), .res_odd(res_odd), .res_ok(res_ok),
    .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every result strobe against the scoreboard and watches grant exclusivity
  always @(negedge clk) begin
    if (!rst) check("gnt_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
    if (res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = sb_q.pop_front();
        check("result{id,even,odd,ok}", {28'd0, res_id, res_even, res_odd, res_ok}, {28'd0, e});
      end
    end
  end

  // Starts in IDLE at a negedge, returns at the negedge after the RESP cycle.
  task automatic run_check(input logic r0, input logic r1,
                           input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                           input logic cfg, input logic cfg_late, input logic drop,
                           input logic clr_in_resp,
                           input logic exp_id, input logic exp_odd, input logic exp_ok,
                           output time t_gnt);
    int unsigned waited;
    bit got;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; cfg_odd = cfg;
    got = 0; waited = 0; t_gnt = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (gnt0 || gnt1) got = 1;
    end
    check("gnt_timeout", {31'd0, got}, 32'd1);
    if (!got) return;
    check("gnt_latency", waited, 32'd1);
    check("gnt_id", {30'd0, gnt1, gnt0}, exp_id ? 32'd2 : 32'd1);
    t_gnt = $time;
    sb_q.push_back({exp_id, ~exp_odd, exp_odd, exp_ok});
    cfg_odd = cfg_late;
    if (drop) begin req0 = 1'b0; req1 = 1'b0; end
    @(negedge clk);
    check("res_valid_latency", {31'd0, res_valid}, 32'd1);
    if (clr_in_resp) clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_odd = 1'b0; clr_cnt = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {22'd0, gnt0, gnt1, res_valid, res_id, res_even, res_odd, res_ok, 3'd0},
          32'd0);
    check("reset_cnt", {16'd0, err_cnt0, err_cnt1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("idle_no_res_valid", {31'd0, res_valid}, 32'd0);

    // Even word, even expected: pass
    run_check(1, 0, 9'b101010111, '0, 0, 0, 1, 0, 0, 0, 1, t_now);
    check("err_cnt0_after_pass", {24'd0, err_cnt0}, 32'd0);

    // Odd word from requester 1, even expected: mismatch
    run_check(0, 1, '0, 9'b101110111, 0, 0, 1, 0, 1, 1, 0, t_now);
    check("err_cnt1_after_fail", {24'd0, err_cnt1}, 32'd1);
    check("res_held_id", {31'd0, res_id}, 32'd1);
    check("res_held_odd", {31'd0, res_odd}, 32'd1);

    // Both held: alternate 0,1,0,1 with grants 3 cycles apart
    run_check(1, 1, 9'b101010111, 9'b101110111, 0, 0, 0, 0, 0, 0, 1, t_prev);
    for (int k = 1; k < 4; k++) begin
      run_check(1, 1, 9'b101010111, 9'b101110111, 0, 0, (k == 3), 0,
                k[0], k[0], !k[0], t_now);
      check("gnt_spacing", 32'(t_now - t_prev), 32'd30);
      t_prev = t_now;
    end
    check("err_cnt1_after_ties", {24'd0, err_cnt1}, 32'd3);
    check("err_cnt0_after_ties", {24'd0, err_cnt0}, 32'd0);

    // 260 mismatches saturate at 255
    for (int k = 0; k < 260; k++)
      run_check(1, 0, 9'b110000111, '0, 0, 0, 1, 0, 0, 1, 0, t_now);
    check("err_cnt0_saturated", {24'd0, err_cnt0}, 32'd255);

    // Clear on the same edge as a mismatch increment
    run_check(1, 0, 9'b110000111, '0, 0, 0, 1, 1, 0, 1, 0, t_now);
    check("err_cnt0_cleared", {24'd0, err_cnt0}, 32'd0);
    check("err_cnt1_cleared", {24'd0, err_cnt1}, 32'd0);

    // cfg_odd flips during CHECK; captured value 0 governs
    run_check(1, 0, 9'b101111011, '0, 0, 1, 1, 0, 0, 1, 0, t_now);
    check("err_cnt0_after_cfg_flip", {24'd0, err_cnt0}, 32'd1);
    cfg_odd = 1'b0;

    // Reset during CHECK abandons the check
    req0 = 1'b1; data0 = 9'b100000111;
    @(negedge clk);
    check("gnt0_before_abort", {30'd0, gnt1, gnt0}, 32'd1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("abort_outputs",
          {22'd0, gnt0, gnt1, res_valid, res_id, res_even, res_odd, res_ok, 3'd0},
          32'd0);
    check("abort_cnt", {16'd0, err_cnt0, err_cnt1}, 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_res_valid", {31'd0, res_valid}, 32'd0);
    end

    // Tie after reset goes to requester 0
    run_check(1, 1, 9'b101010111, 9'b101110111, 0, 0, 1, 0, 0, 0, 1, t_now);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
